// File: rtl/timer_core.sv
// Stopwatch core: divides clk into 1 s ticks and counts BCD m:ss under start/pause/clear,
// raising timeout and freezing once the programmed limit is reached.
module timer_core #(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned LIMIT_MIN = 2,
    parameter int unsigned LIMIT_SEC = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       clear,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_cnt,
    output logic       min,
    output logic       timeout,
    output logic       running
);

    localparam int unsigned    PreW   = $clog2(TICK_DIV);
    localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
    localparam logic [3:0]     LimLo  = 4'(LIMIT_SEC % 10);
    localparam logic [3:0]     LimHi  = 4'(LIMIT_SEC / 10);
    localparam logic [3:0]     LimMin = 4'(LIMIT_MIN);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e          state_q, state_d;
    logic [PreW-1:0] pre_q, pre_d;
    logic [3:0]      sec_lo_q, sec_lo_d;
    logic [3:0]      sec_hi_q, sec_hi_d;
    logic [3:0]      min_cnt_q, min_cnt_d;
    logic            min_q, min_d;
    logic            timeout_q, timeout_d;

    logic            tick;
    logic            at_limit;
    logic [3:0]      inc_lo, inc_hi, inc_min;

    // Digits as they would read after one more second
    always_comb begin
        inc_lo  = sec_lo_q + 4'd1;
        inc_hi  = sec_hi_q;
        inc_min = min_cnt_q;
        if (sec_lo_q == 4'd9) begin
            inc_lo = 4'd0;
            if (sec_hi_q == 4'd5) begin
                inc_hi  = 4'd0;
                inc_min = min_cnt_q + 4'd1;
            end else begin
                inc_hi = sec_hi_q + 4'd1;
            end
        end
    end

    assign tick     = (state_q == StRun) && (pre_q == PreMax);
    assign at_limit = (inc_lo == LimLo) && (inc_hi == LimHi) && (inc_min == LimMin);

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        sec_lo_d  = sec_lo_q;
        sec_hi_d  = sec_hi_q;
        min_cnt_d = min_cnt_q;
        min_d     = min_q;
        timeout_d = timeout_q;

        if (clear) begin
            state_d   = StIdle;
            pre_d     = '0;
            sec_lo_d  = 4'd0;
            sec_hi_d  = 4'd0;
            min_cnt_d = 4'd0;
            min_d     = 1'b0;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    pre_d = '0;
                    if (start) state_d = StRun;
                end
                StRun: begin
                    if (tick) begin
                        pre_d     = '0;
                        sec_lo_d  = inc_lo;
                        sec_hi_d  = inc_hi;
                        min_cnt_d = inc_min;
                        min_d     = (inc_min != 4'd0);
                        // Reaching the limit takes precedence over a coincident start
                        if (at_limit) begin
                            timeout_d = 1'b1;
                            state_d   = StDone;
                        end else if (start) begin
                            state_d = StPause;
                        end
                    end else begin
                        pre_d = pre_q + PreW'(1);
                        if (start) state_d = StPause;
                    end
                end
                StPause: begin
                    if (start) state_d = StRun;
                end
                StDone: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pre_q     <= '0;
            sec_lo_q  <= 4'd0;
            sec_hi_q  <= 4'd0;
            min_cnt_q <= 4'd0;
            min_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            sec_lo_q  <= sec_lo_d;
            sec_hi_q  <= sec_hi_d;
            min_cnt_q <= min_cnt_d;
            min_q     <= min_d;
            timeout_q <= timeout_d;
        end
    end

    assign sec_lo  = sec_lo_q;
    assign sec_hi  = sec_hi_q;
    assign min_cnt = min_cnt_q;
    assign min     = min_q;
    assign timeout = timeout_q;
    assign running = (state_q == StRun);

endmodule

// File: tb/tb_timer_core.sv
// Bench for timer_core: directed scenarios plus random start/clear/rst traffic, each cycle
// compared against an elapsed-seconds reference model.
module tb_timer_core;

    localparam int unsigned TD = 4;
    localparam int unsigned LM = 1;
    localparam int unsigned LS = 5;
    localparam int          LimitTotal = LM * 60 + LS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sec_lo, sec_hi, min_cnt;
    logic       min, timeout, running;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model: elapsed seconds, prescaler phase, mode (0 idle,1 run,2 pause,3 done)
    int m_sec  = 0;
    int m_pre  = 0;
    int m_mode = 0;
    int m_to   = 0;

    timer_core #(
        .TICK_DIV (TD),
        .LIMIT_MIN(LM),
        .LIMIT_SEC(LS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .clear  (clear),
        .sec_lo (sec_lo),
        .sec_hi (sec_hi),
        .min_cnt(min_cnt),
        .min    (min),
        .timeout(timeout),
        .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit c);
        if (r || c) begin
            m_sec = 0; m_pre = 0; m_mode = 0; m_to = 0;
        end else begin
            case (m_mode)
                0: begin
                    m_pre = 0;
                    if (s) m_mode = 1;
                end
                1: begin
                    if (m_pre == TD - 1) begin
                        m_pre = 0;
                        m_sec++;
                        if (m_sec == LimitTotal) begin
                            m_mode = 3;
                            m_to   = 1;
                        end else if (s) begin
                            m_mode = 2;
                        end
                    end else begin
                        m_pre++;
                        if (s) m_mode = 2;
                    end
                end
                2: if (s) m_mode = 1;
                default: ;
            endcase
        end
    endtask

    task automatic check_model();
        chk("sec_lo",  {28'b0, sec_lo},  32'(m_sec % 10));
        chk("sec_hi",  {28'b0, sec_hi},  32'((m_sec % 60) / 10));
        chk("min_cnt", {28'b0, min_cnt}, 32'(m_sec / 60));
        chk("min",     {31'b0, min},     32'(m_sec >= 60));
        chk("timeout", {31'b0, timeout}, 32'(m_to));
        chk("running", {31'b0, running}, 32'(m_mode == 1));
    endtask

    task automatic step(input bit s, input bit c, input bit r);
        start = s; clear = c; rst = r;
        @(posedge clk);
        model_edge(r, s, c);
        #1;
        check_model();
        start = 1'b0; clear = 1'b0; rst = 1'b0;
    endtask

    // Idle-step until the model shows the wanted time (and prescaler phase, unless tp < 0)
    task automatic run_until(input int ts, input int tp, input string tag);
        bit found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (m_sec == ts && (tp < 0 || m_pre == tp)) found = 1;
            else step(0, 0, 0);
        end
        if (!found) begin
            n_checks++;
            n_errs++;
            $error("FAIL wait_%s: observed sec=%0d expected sec=%0d", tag, m_sec, ts);
        end
    endtask

    initial begin
        step(0, 0, 1);
        step(0, 0, 1);
        chk("rst_running", {31'b0, running}, 32'd0);
        chk("rst_sec_lo", {28'b0, sec_lo}, 32'd0);

        // start at edge 0, first tick at edge 4, second at edge 8
        step(1, 0, 0);
        chk("start_running", {31'b0, running}, 32'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        chk("pre_tick", {28'b0, sec_lo}, 32'd0);
        step(0, 0, 0);
        chk("tick1", {28'b0, sec_lo}, 32'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        chk("tick2", {28'b0, sec_lo}, 32'd2);
        chk("tick2_min", {31'b0, min}, 32'd0);

        // Pause with a partial prescaler, then resume from it
        run_until(3, 2, "pause");
        step(1, 0, 0);
        chk("pause_running", {31'b0, running}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0);
            chk("pause_frozen", {28'b0, sec_lo}, 32'd3);
        end
        step(1, 0, 0);
        chk("resume_running", {31'b0, running}, 32'd1);
        chk("resume_hold", {28'b0, sec_lo}, 32'd3);
        step(0, 0, 0);
        chk("resume_tick", {28'b0, sec_lo}, 32'd4);

        // start coincident with tick at 0:09
        run_until(9, 3, "tick_start");
        step(1, 0, 0);
        chk("ts_sec_hi", {28'b0, sec_hi}, 32'd1);
        chk("ts_sec_lo", {28'b0, sec_lo}, 32'd0);
        chk("ts_running", {31'b0, running}, 32'd0);
        step(1, 0, 0);

        // Minute rollover
        run_until(59, 3, "rollover");
        step(0, 0, 0);
        chk("roll_min_cnt", {28'b0, min_cnt}, 32'd1);
        chk("roll_sec_hi", {28'b0, sec_hi}, 32'd0);
        chk("roll_sec_lo", {28'b0, sec_lo}, 32'd0);
        chk("roll_min", {31'b0, min}, 32'd1);

        // Limit reached at 1:05
        run_until(LimitTotal, -1, "limit");
        chk("lim_timeout", {31'b0, timeout}, 32'd1);
        chk("lim_running", {31'b0, running}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            step(i % 2 == 0, 0, 0);
            chk("done_hold", {20'b0, min_cnt, sec_hi, sec_lo}, 32'h105);
            chk("done_timeout", {31'b0, timeout}, 32'd1);
        end
        step(0, 1, 0);
        chk("clr_digits", {20'b0, min_cnt, sec_hi, sec_lo}, 32'h000);
        chk("clr_timeout", {31'b0, timeout}, 32'd0);
        chk("clr_min", {31'b0, min}, 32'd0);

        // start and clear together during RUN
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        step(1, 1, 0);
        chk("sc_running", {31'b0, running}, 32'd0);
        chk("sc_digits", {20'b0, min_cnt, sec_hi, sec_lo}, 32'h000);

        // Reset mid-count at 0:37
        step(1, 0, 0);
        run_until(37, -1, "rst_mid");
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        chk("rstmid_digits", {20'b0, min_cnt, sec_hi, sec_lo}, 32'h000);
        chk("rstmid_running", {31'b0, running}, 32'd0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0,
                 $urandom_range(0, 999) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
